// File: rtl/riscv_pkg.sv
// Shared core package: RISC-V opcode encoding plus the types used by the
// unified memory-port arbiter.
//   opcode_t     : major opcode field (instr[6:0])
//   arb_state_t  : arbiter FSM state
//   ARB_STARVE_W : width of the arbiter starvation counter
package riscv_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_OP_IMM = 7'b0010011,
        OP_OP     = 7'b0110011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arb_state_t;

    localparam int ARB_STARVE_W = 4;

endpackage

// File: rtl/arb_perf_counter.sv
// Free-running 32-bit event counter for the memory-port arbiter.
//   clk, rst (async, active-high) : clock / reset (count -> 0)
//   inc                           : count this cycle
//   count[31:0]                   : event total, wraps on overflow
module arb_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      count <= '0;
        else if (inc) count <= count + 32'd1;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single unified memory port between instruction fetch (if_*)
// and the load/store stage (d_*). Data wins over fetch, except that after
// MAX_STARVE consecutive data grants with a fetch waiting, fetch is forced.
// ctrl_hold freezes the pipeline from data request until data completion.
//   if_req/if_addr -> if_gnt, if_rvalid, if_rdata     : fetch side
//   d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid, d_rdata : load/store side
//   mem_req/mem_we/mem_addr/mem_wdata <- mem_ready/mem_rdata : memory side
//   ctrl_hold                                          : pipeline hold
// Optional build macro ARB_PERF_CNT_EN adds perf_i_cnt, perf_d_cnt and
// perf_stall_cnt (completed fetches, completed data accesses, hold cycles).
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ctrl_hold
`ifdef ARB_PERF_CNT_EN
   ,output logic [31:0]       perf_i_cnt,
    output logic [31:0]       perf_d_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam logic [ARB_STARVE_W-1:0] STARVE_LIM = ARB_STARVE_W'(MAX_STARVE);

    arb_state_t              state;
    logic [ARB_STARVE_W-1:0] starve_cnt;
    logic                    force_if;

    assign force_if  = (starve_cnt == STARVE_LIM) && if_req;
    assign ctrl_hold = d_req | (state == BUSY_D);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            if_gnt     <= 1'b0;
            d_gnt      <= 1'b0;
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            // gnt / rvalid are single-cycle pulses
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_req && !force_if) begin
                        d_gnt     <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        state     <= BUSY_D;
                        // only grants that overtake a waiting fetch count
                        if (if_req && starve_cnt != STARVE_LIM)
                            starve_cnt <= starve_cnt + 1'b1;
                    end else if (if_req) begin
                        if_gnt     <= 1'b1;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        state      <= BUSY_I;
                        starve_cnt <= '0;
                    end
                end
                BUSY_I: begin
                    if (mem_ready) begin
                        mem_req   <= 1'b0;
                        if_rdata  <= mem_rdata;
                        if_rvalid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        // a store only acks; load data register keeps its value
                        if (!mem_we) d_rdata <= mem_rdata;
                        d_rvalid <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic i_done, d_done;
    assign i_done = (state == BUSY_I) && mem_ready;
    assign d_done = (state == BUSY_D) && mem_ready;

    arb_perf_counter u_perf_i (.clk(clk), .rst(rst), .inc(i_done),    .count(perf_i_cnt));
    arb_perf_counter u_perf_d (.clk(clk), .rst(rst), .inc(d_done),    .count(perf_d_cnt));
    arb_perf_counter u_perf_s (.clk(clk), .rst(rst), .inc(ctrl_hold), .count(perf_stall_cnt));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Expected read data is pushed into
// per-requester queues when a request is issued and popped on rvalid.
// The memory model raises mem_ready (registered) once mem_req has been seen
// for mem_lat+1 cycles; read data is a fixed function of the address.
module tb_mem_port_arbiter;
    import riscv_pkg::*;

    logic        clk, rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        ctrl_hold;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_i_cnt, perf_d_cnt, perf_stall_cnt;
`endif

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STARVE(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .ctrl_hold(ctrl_hold)
`ifdef ARB_PERF_CNT_EN
       ,.perf_i_cnt(perf_i_cnt), .perf_d_cnt(perf_d_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : ((a ^ 32'hA5A5_0000) + 32'h1111);
    endfunction

    // memory model
    int mem_lat;
    int mem_cnt;
    assign mem_rdata = rd_word(mem_addr);
    always @(posedge clk) begin
        if (rst || !mem_req || mem_ready) begin
            mem_ready <= 1'b0;
            mem_cnt   <= 0;
        end else if (mem_cnt >= mem_lat) begin
            mem_ready <= 1'b1;
        end else begin
            mem_cnt <= mem_cnt + 1;
        end
    end

    int n_asrt = 0;
    int n_fail = 0;
    int hold_cnt = 0;
    logic [31:0] iq[$];
    logic [31:0] dq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one clock: tally hold at mid-cycle, then sample #1 after the edge and
    // score any rvalid against the queues
    task automatic step();
        @(negedge clk);
        if (ctrl_hold === 1'b1) hold_cnt++;
        @(posedge clk);
        #1;
        if (if_rvalid) begin
            if (iq.size() == 0) chk("if_rvalid unexpected", 32'd1, 32'd0);
            else                chk("if_rdata", if_rdata, iq.pop_front());
        end
        if (d_rvalid) begin
            if (dq.size() == 0) chk("d_rvalid unexpected", 32'd1, 32'd0);
            else                chk("d_rdata", d_rdata, dq.pop_front());
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    int  n, dg, ig;
    bit  done;

    initial begin
        rst = 1'b1; mem_lat = 0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        step(); step();
        chk("rst gnt/rvalid/req/we/hold",
            {27'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req | mem_we | ctrl_hold}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst rdata", if_rdata | d_rdata, 32'd0);
        chk("rst state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;

        // 1: lone fetch, zero-wait memory
        if_req = 1; if_addr = 32'h10; iq.push_back(32'hDEAD_BEEF);
        step();
        chk("s1 c1 if_gnt", 32'(if_gnt), 32'd1);
        chk("s1 c1 mem_req", 32'(mem_req), 32'd1);
        chk("s1 c1 mem_addr", mem_addr, 32'h10);
        if_req = 0;
        step();
        chk("s1 c2 mem_req/gnt", {30'd0, mem_req, if_gnt}, 32'b10);
        step();
        chk("s1 c3 if_rvalid", 32'(if_rvalid), 32'd1);
        chk("s1 c3 mem_req", 32'(mem_req), 32'd0);
        step();
        chk("s1 c4 if_rvalid", 32'(if_rvalid), 32'd0);

        // 2: simultaneous fetch and load, data first
        if_req = 1; if_addr = 32'h24; d_req = 1; d_we = 0; d_addr = 32'h200;
        dq.push_back(rd_word(32'h200)); iq.push_back(rd_word(32'h24));
        step();
        chk("s2 c1 d_gnt/if_gnt", {30'd0, d_gnt, if_gnt}, 32'b10);
        chk("s2 c1 mem_addr", mem_addr, 32'h200);
        d_req = 0;
        step();
        chk("s2 c2 ctrl_hold", 32'(ctrl_hold), 32'd1);
        step();
        chk("s2 c3 d_rvalid/hold", {30'd0, d_rvalid, ctrl_hold}, 32'b10);
        step();
        chk("s2 c4 if_gnt", 32'(if_gnt), 32'd1);
        chk("s2 c4 mem_addr", mem_addr, 32'h24);
        chk("s2 starve cleared", 32'(dut.starve_cnt), 32'd0);
        if_req = 0;
        step(); step(); step();

        // 3: starvation guard
        pulse_rst();
        hold_cnt = 0;
        if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h300;
        iq.push_back(rd_word(32'h80));
        dg = 0; ig = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            step();
            if (d_gnt) begin
                dg++;
                dq.push_back(rd_word(32'h300));
                if (dg == 4) chk("s3 starve at 4th D", 32'(dut.starve_cnt), 32'd4);
            end
            if (if_gnt) begin
                ig++;
                done = 1;
                chk("s3 D grants before forced I", dg, 32'd4);
                chk("s3 starve after I", 32'(dut.starve_cnt), 32'd0);
                if_req = 0; d_req = 0;
            end
        end
        if (!done) chk("s3 forced if_gnt timeout", 32'd0, 32'd1);
        for (int c = 0; c < 4; c++) step();
`ifdef ARB_PERF_CNT_EN
        chk("s6 perf_d_cnt", perf_d_cnt, 32'd4);
        chk("s6 perf_i_cnt", perf_i_cnt, 32'd1);
        chk("s6 perf_stall_cnt", perf_stall_cnt, hold_cnt);
`endif

        // 4: store with wait states, mem side held 4 cycles
        mem_lat = 2;
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h1234;
        dq.push_back(rd_word(32'h300));     // store ack leaves last load data
        step();
        chk("s4 c1 d_gnt", 32'(d_gnt), 32'd1);
        d_req = 0; d_we = 0;
        n = 0;
        while (mem_req && n < 10) begin
            n++;
            chk("s4 mem side stable", mem_addr ^ mem_wdata ^ {31'd0, mem_we}, 32'h40 ^ 32'h1234 ^ 32'd1);
            step();
        end
        chk("s4 mem_req cycles", n, 32'd4);
        chk("s4 d_rvalid", 32'(d_rvalid), 32'd1);

        // 5: async reset while a load is outstanding
        mem_lat = 5;
        step();
        d_req = 1; d_addr = 32'h500;
        step();
        chk("s5 c1 d_gnt", 32'(d_gnt), 32'd1);
        d_req = 0;
        step();
        chk("s5 busy hold", 32'(ctrl_hold), 32'd1);
        rst = 1'b1;
        #1;
        chk("s5 async req/hold", {30'd0, mem_req, ctrl_hold}, 32'd0);
        #1 rst = 1'b0;
        for (int c = 0; c < 8; c++) step();
        chk("s5 state after release", 32'(dut.state), 32'(IDLE));

        // 7: fetch request withdrawn while port busy gets no grant
        mem_lat = 0;
        d_req = 1; d_addr = 32'h600; dq.push_back(rd_word(32'h600));
        step();
        d_req = 0; if_req = 1; if_addr = 32'h700;
        step();
        if_req = 0;
        step(); step();
        chk("s7 no if_gnt", {30'd0, if_gnt, mem_req}, 32'd0);
        step();

        chk("queues drained", iq.size() + dq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
